// File: rtl/gray_ptr_sync.sv
// Destination-domain synchroniser for a Gray-coded async FIFO pointer.
// It produces the synced Gray value, its registered binary decode, a change strobe with an advance delta, and a sticky Gray-violation flag.
module gray_ptr_sync #(
    parameter int ADDR_WIDTH = 3,
    parameter int STAGES     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_WIDTH:0] data_in,
    input  logic                clr_err,
    output logic [ADDR_WIDTH:0] sync_gray,
    output logic [ADDR_WIDTH:0] sync_bin,
    output logic                ptr_changed,
    output logic [ADDR_WIDTH:0] delta,
    output logic                gray_err
);

    localparam int W = ADDR_WIDTH + 1;

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("gray_ptr_sync: STAGES must be in 2..4");
    end

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [STAGES-1:0][W-1:0] stage_q, stage_d;
    logic [W-1:0] prev_q, prev_d;
    logic [W-1:0] bin_q, bin_d;
    logic         chg_q, chg_d;
    logic [W-1:0] delta_q, delta_d;
    logic         err_q, err_d;

    logic [W-1:0] diff;
    logic [W-1:0] bin_cur, bin_prev;
    logic         changed, multi_bit;

    // Plain flop chain: no logic between stages so each flop can resolve metastability.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = data_in;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    assign sync_gray = stage_q[STAGES-1];

    always_comb begin
        diff      = sync_gray ^ prev_q;
        changed   = |diff;
        // Clearing the lowest set bit leaves a nonzero value only if two or more bits differed.
        multi_bit = |(diff & (diff - W'(1)));
        bin_cur   = g2b(sync_gray);
        bin_prev  = g2b(prev_q);

        prev_d  = sync_gray;
        bin_d   = bin_cur;
        chg_d   = changed;
        delta_d = delta_q;
        if (changed) begin
            delta_d = bin_cur - bin_prev;
        end

        err_d = err_q;
        if (clr_err) begin
            err_d = 1'b0;
        end
        if (multi_bit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            prev_q  <= '0;
            bin_q   <= '0;
            chg_q   <= 1'b0;
            delta_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stage_q <= stage_d;
            prev_q  <= prev_d;
            bin_q   <= bin_d;
            chg_q   <= chg_d;
            delta_q <= delta_d;
            err_q   <= err_d;
        end
    end

    assign sync_bin    = bin_q;
    assign ptr_changed = chg_q;
    assign delta       = delta_q;
    assign gray_err    = err_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync: one instance with STAGES=2 and one with STAGES=3, both driven by shared stimulus.
module tb_gray_ptr_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] data_in;
    logic       clr_err;

    logic [3:0] g2_gray, g2_bin, g2_delta;
    logic       g2_chg, g2_err;
    logic [3:0] g3_gray, g3_bin, g3_delta;
    logic       g3_chg, g3_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_ptr_sync #(.ADDR_WIDTH(3), .STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .data_in(data_in), .clr_err(clr_err),
        .sync_gray(g2_gray), .sync_bin(g2_bin), .ptr_changed(g2_chg),
        .delta(g2_delta), .gray_err(g2_err)
    );

    gray_ptr_sync #(.ADDR_WIDTH(3), .STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .data_in(data_in), .clr_err(clr_err),
        .sync_gray(g3_gray), .sync_bin(g3_bin), .ptr_changed(g3_chg),
        .delta(g3_delta), .gray_err(g3_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One active edge, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst     = 1'b1;
        data_in = 4'b1010;
        clr_err = 1'b0;
        tick(5);
        chk("rst_gray",  32'(g2_gray),  32'h0);
        chk("rst_bin",   32'(g2_bin),   32'h0);
        chk("rst_chg",   32'(g2_chg),   32'h0);
        chk("rst_delta", 32'(g2_delta), 32'h0);
        chk("rst_err",   32'(g2_err),   32'h0);
        chk("rst_gray3", 32'(g3_gray),  32'h0);

        // Leave reset: 1010 reaches sync_gray at edge 2, decoded at edge 3.
        rst = 1'b0;
        tick(1);
        chk("rel_e1_gray", 32'(g2_gray), 32'h0);
        tick(1);
        chk("rel_e2_gray", 32'(g2_gray), 32'ha);
        chk("rel_e2_chg",  32'(g2_chg),  32'h0);
        tick(1);
        chk("rel_e3_bin",   32'(g2_bin),   32'hc);
        chk("rel_e3_chg",   32'(g2_chg),   32'h1);
        chk("rel_e3_delta", 32'(g2_delta), 32'hc);
        chk("rel_e3_err",   32'(g2_err),   32'h1);
        tick(1);
        chk("rel_e4_chg", 32'(g2_chg), 32'h0);

        // Settle at 0000 and clear the flag.
        data_in = 4'b0000;
        tick(4);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("setup_clr_err", 32'(g2_err), 32'h0);

        // Single increment 0 -> 1.
        data_in = 4'b0001;
        tick(2);
        chk("inc_e2_gray", 32'(g2_gray), 32'h1);
        chk("inc_e2_chg",  32'(g2_chg),  32'h0);
        tick(1);
        chk("inc_e3_bin",   32'(g2_bin),   32'h1);
        chk("inc_e3_chg",   32'(g2_chg),   32'h1);
        chk("inc_e3_delta", 32'(g2_delta), 32'h1);
        chk("inc_e3_err",   32'(g2_err),   32'h0);
        tick(1);
        chk("inc_e4_chg",   32'(g2_chg),   32'h0);
        chk("inc_e4_delta", 32'(g2_delta), 32'h1);

        // Park at bin 15 (gray 1000), clear the flag raised on the way, then wrap to 0.
        data_in = 4'b1000;
        tick(4);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("wrap_pre_bin", 32'(g2_bin), 32'hf);
        chk("wrap_pre_err", 32'(g2_err), 32'h0);
        data_in = 4'b0000;
        tick(3);
        chk("wrap_bin",   32'(g2_bin),   32'h0);
        chk("wrap_chg",   32'(g2_chg),   32'h1);
        chk("wrap_delta", 32'(g2_delta), 32'h1);
        chk("wrap_err",   32'(g2_err),   32'h0);
        tick(1);
        chk("wrap_chg_off", 32'(g2_chg), 32'h0);

        // Multi-bit jump gray 0000 -> 0011 (bin 2).
        data_in = 4'b0011;
        tick(3);
        chk("jump_bin",   32'(g2_bin),   32'h2);
        chk("jump_delta", 32'(g2_delta), 32'h2);
        chk("jump_err",   32'(g2_err),   32'h1);
        tick(10);
        chk("jump_err_sticky", 32'(g2_err), 32'h1);
        chk("jump_chg_off",    32'(g2_chg), 32'h0);

        // Clear with no change in flight.
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("clr_err", 32'(g2_err), 32'h0);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("clr_idle_err", 32'(g2_err), 32'h0);

        // Clear on the same edge as a new 2-bit jump (0011 -> 0000): set wins.
        data_in = 4'b0000;
        tick(2);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("clr_vs_set_err",   32'(g2_err),   32'h1);
        chk("clr_vs_set_chg",   32'(g2_chg),   32'h1);
        chk("clr_vs_set_delta", 32'(g2_delta), 32'he);
        tick(4);

        // STAGES=3: increment 0 -> 1 reaches sync_bin at edge 4.
        data_in = 4'b0001;
        tick(2);
        chk("s3_e2_gray", 32'(g3_gray), 32'h0);
        tick(1);
        chk("s3_e3_gray", 32'(g3_gray), 32'h1);
        chk("s3_e3_bin",  32'(g3_bin),  32'h0);
        tick(1);
        chk("s3_e4_bin",   32'(g3_bin),   32'h1);
        chk("s3_e4_chg",   32'(g3_chg),   32'h1);
        chk("s3_e4_delta", 32'(g3_delta), 32'h1);
        chk("pre_rst_bin2", 32'(g2_bin), 32'h1);

        // Reset between edges clears everything without a clock.
        rst = 1'b1;
        #2;
        chk("mid_rst_gray3",  32'(g3_gray),  32'h0);
        chk("mid_rst_bin3",   32'(g3_bin),   32'h0);
        chk("mid_rst_chg3",   32'(g3_chg),   32'h0);
        chk("mid_rst_delta3", 32'(g3_delta), 32'h0);
        chk("mid_rst_err3",   32'(g3_err),   32'h0);
        chk("mid_rst_gray2",  32'(g2_gray),  32'h0);
        chk("mid_rst_bin2",   32'(g2_bin),   32'h0);
        chk("mid_rst_delta2", 32'(g2_delta), 32'h0);
        chk("mid_rst_err2",   32'(g2_err),   32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_ptr_sync.md
Name: gray_ptr_sync

Overview:
- Parametrised N-stage synchroniser for a Gray-coded async FIFO pointer, clocked entirely in the destination domain.
- Adds the following on top of the plain 2-FF synchroniser:
  - configurable stage count
  - registered Gray-to-binary decode
  - change strobe with pointer advance delta
  - sticky Gray-violation error flag
- Sits between the remote pointer register and the local full/empty logic of the async FIFO.

Parameters:
- ADDR_WIDTH, 3, FIFO address width; pointer width is ADDR_WIDTH+1 (MSB = wrap bit).
- STAGES, 2, synchroniser flop count; legal range 2..4; any other value is an elaboration error.

Ports:
- clk  input  1  destination-domain clock.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  ADDR_WIDTH+1  Gray-coded pointer from the source domain (asynchronous to clk).
- clr_err  input  1  synchronous clear of gray_err.
- sync_gray  output  ADDR_WIDTH+1  synchronised Gray pointer (last synchroniser stage).
- sync_bin  output  ADDR_WIDTH+1  binary decode of sync_gray, registered.
- ptr_changed  output  1  one-cycle strobe: sync_gray differs from its previous-cycle value.
- delta  output  ADDR_WIDTH+1  binary advance since the previous sample, modulo 2^(ADDR_WIDTH+1); valid when ptr_changed=1, holds its last value otherwise.
- gray_err  output  1  sticky flag: a sample changed more than one Gray bit.

Behaviour:
- Reset:
  - rst=1 asynchronously clears every register: all sync stages, the prev register, sync_gray, sync_bin, ptr_changed, delta and gray_err are all 0.
  - The block leaves reset on the first clk edge with rst=0.
  - Reset asserted mid-operation clears all outputs immediately, without waiting for a clock edge.
- Synchroniser chain:
  - stage[0] <= data_in; stage[i] <= stage[i-1]; sync_gray = stage[STAGES-1].
  - Latency: a value stable on data_in before edge k appears on sync_gray after edge k+STAGES-1.
  - No logic between stages; every stage is a plain flop.
- Post-sync stage, all updated on the same edge from the current sync_gray and prev:
  - prev <= sync_gray
  - sync_bin <= g2b(sync_gray), where g2b: b[MSB]=g[MSB], b[i]=b[i+1]^g[i]
  - ptr_changed <= (sync_gray != prev)
  - delta <= g2b(sync_gray) - g2b(prev), truncated to ADDR_WIDTH+1 bits (wraps naturally); loaded only when the change condition is true
  - gray_err set when popcount(sync_gray ^ prev) > 1
- End-to-end latency from data_in to sync_bin/ptr_changed: STAGES+1 edges.
- ptr_changed: exactly one cycle high per distinct new sync_gray value. Consecutive changes give a continuous high.
- Wrap-around: pointer max -> 0 is a single-bit Gray change. Result: delta=1, no error.
- gray_err clear rules:
  - cleared on the edge where clr_err=1, unless a new violation is detected on the same edge; set wins.
  - clr_err while gray_err=0 has no effect.
- Tolerated input transitions:
  - a sample caught mid-transition resolves to either the old or the new value; both are legal Gray neighbours.
  - no error is raised for single-bit changes.

Test Plan:
- Reset values: rst=1 with data_in=4'b1010 for 5 clks -> all outputs 0. Release rst -> with STAGES=2, sync_gray=1010 after 2 edges, sync_bin=1100 (12) and ptr_changed=1 on the 3rd edge, delta=12, gray_err=1 (a 2-bit change from 0000).
- Single increment, STAGES=2: from settled gray 0000, drive 0001 -> sync_gray=0001 at edge 2; at edge 3 sync_bin=1, ptr_changed=1 for exactly one cycle, delta=1, gray_err=0.
- Wrap, ADDR_WIDTH=3: settled at bin 15 (gray 1000), drive gray 0000 -> sync_bin=0, ptr_changed pulse, delta=1, gray_err=0.
- Multi-bit jump: settled gray 0000, drive 0011 (bin 2) in one step -> delta=2, gray_err=1 and stays 1 for 10 further clks.
- Error clear:
  - assert clr_err one cycle with no change -> gray_err=0 next edge.
  - repeat with clr_err on the same edge as a new 2-bit jump -> gray_err stays 1.
- STAGES=3 latency and mid-run reset: increment 0->1 -> sync_bin=1 at edge 4. Assert rst between clock edges -> all outputs 0 immediately.
